// File: rtl/mmio_uart_tx_if.sv
// Data-bus responder port of the console UART: the processor side drives the
// request fields; the UART returns combinational read data and a select flag.
interface mmio_uart_tx_if;
  logic        re_in;
  logic        we_in;
  logic [1:0]  width_in;
  logic [31:0] addr_in;
  logic [31:0] wdata_in;
  logic [31:0] rdata_out;
  logic        sel_out;

  modport master (
    output re_in, we_in, width_in, addr_in, wdata_in,
    input  rdata_out, sel_out
  );

  modport slave (
    input  re_in, we_in, width_in, addr_in, wdata_in,
    output rdata_out, sel_out
  );
endinterface

// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 console transmitter: stores to TXDATA are queued in a small
// FIFO and shifted out LSB first at one bit per 'div' clock cycles.
//
// state | meaning
// IDLE  | line high, waiting for a queued byte
// START | start bit (low) for div cycles
// DATA  | shift[0] on the line, eight bits of div cycles each
// STOP  | stop bit (high); at its last cycle chain straight into the next byte
module mmio_uart_tx #(
  parameter logic [31:0] BASE_ADDR  = 32'h0000_2000,
  parameter int          FIFO_DEPTH = 4,
  parameter logic [15:0] DIV_RESET  = 16'd4
) (
  input  logic          clk,
  input  logic          rst,
  mmio_uart_tx_if.slave bus,
  output logic          tx_out,
  output logic          irq_out
);
  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t        state, state_nxt;
  logic [7:0]    mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic [15:0]   div, div_frame, cyc_cnt, div_wr, div_raw;
  logic [2:0]    bit_cnt;
  logic [7:0]    shift;
  logic          overflow;
  logic          hit, valid, wr_txdata, wr_status, wr_div;
  logic          full, empty, push, pop, cyc_done, busy;
  logic [1:0]    off;
  logic          unused_wdata_hi;

  assign unused_wdata_hi = ^bus.wdata_in[31:16];

  assign hit       = (bus.addr_in[31:4] == BASE_ADDR[31:4]);
  assign valid     = hit && (bus.addr_in[1:0] == 2'b00) && (bus.width_in != 2'd3);
  assign off       = bus.addr_in[3:2];
  assign wr_txdata = bus.we_in && valid && (off == 2'd0);
  assign wr_status = bus.we_in && valid && (off == 2'd1);
  assign wr_div    = bus.we_in && valid && (off == 2'd2);

  assign full     = (count == DEPTH_C);
  assign empty    = (count == '0);
  assign busy     = (state != IDLE);
  assign cyc_done = (cyc_cnt == 16'd0);
  // A full FIFO drops the byte even if a pop frees a slot on the same edge.
  assign push     = wr_txdata && !full;
  assign pop      = !empty && ((state == IDLE) || ((state == STOP) && cyc_done));
  assign irq_out  = empty && (state == IDLE);

  // Byte writes only touch the low half; a zero divisor would stall the timer.
  assign div_raw = (bus.width_in == 2'd0) ? {div[15:8], bus.wdata_in[7:0]}
                                          : bus.wdata_in[15:0];
  assign div_wr  = (div_raw == 16'd0) ? 16'd1 : div_raw;

  // Combinational register read; reflects state before any concurrent write.
  always_comb begin
    bus.rdata_out = 32'd0;
    bus.sel_out   = hit && (bus.re_in || bus.we_in);
    if (bus.re_in && valid) begin
      case (off)
        2'd1:    bus.rdata_out = {24'd0, 4'(count), overflow, busy, empty, full};
        2'd2:    bus.rdata_out = {16'd0, div};
        default: bus.rdata_out = 32'd0;
      endcase
    end
  end

  // FIFO pointers/occupancy, sticky overflow and the divisor register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
      div      <= DIV_RESET;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
      if (wr_txdata && full) overflow <= 1'b1;
      else if (wr_status)    overflow <= 1'b0;
      if (wr_div) div <= div_wr;
    end
  end

  // FIFO storage needs no reset; occupancy is tracked by count.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= bus.wdata_in[7:0];
  end

  // Serializer state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // Next-state and line drive.
  always_comb begin
    state_nxt = state;
    tx_out    = 1'b1;
    case (state)
      IDLE:  if (pop) state_nxt = START;
      START: begin
        tx_out = 1'b0;
        if (cyc_done) state_nxt = DATA;
      end
      DATA: begin
        tx_out = shift[0];
        if (cyc_done && (bit_cnt == 3'd7)) state_nxt = STOP;
      end
      STOP:  if (cyc_done) state_nxt = pop ? START : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Bit timer (down-counter), bit index and shift register; divisor latched per frame.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shift     <= 8'd0;
      bit_cnt   <= 3'd0;
      cyc_cnt   <= 16'd0;
      div_frame <= DIV_RESET;
    end else if (pop) begin
      shift     <= mem[rd_ptr];
      div_frame <= div;
      cyc_cnt   <= div - 16'd1;
      bit_cnt   <= 3'd0;
    end else if (state != IDLE) begin
      if (cyc_done) begin
        cyc_cnt <= div_frame - 16'd1;
        if (state == DATA) begin
          shift   <= shift >> 1;
          bit_cnt <= bit_cnt + 3'd1;
        end
      end else begin
        cyc_cnt <= cyc_cnt - 16'd1;
      end
    end
  end
endmodule

// File: tb/tb_mmio_uart_tx.sv
// Bench for the console UART: a frame-level model (byte queue plus a 10-bit
// frame pattern stretched by the frame divisor) is compared every cycle, and
// directed scenarios add hand-computed literal checks.
module tb_mmio_uart_tx;
  localparam int FIFO_DEPTH = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic tx, irq;
  int   n_vec = 0;
  int   n_err = 0;

  mmio_uart_tx_if bus();

  mmio_uart_tx #(
    .BASE_ADDR (32'h0000_2000),
    .FIFO_DEPTH(FIFO_DEPTH),
    .DIV_RESET (16'd4)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .bus    (bus),
    .tx_out (tx),
    .irq_out(irq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- frame-level model ----------------
  logic [7:0]  mq[$];
  int          frame_rem;
  int          fdiv;
  logic [9:0]  frame_bits;
  logic [15:0] mdiv;
  logic        movf;
  int          pre_n;
  logic [15:0] div_pre, nd;
  logic [7:0]  popped;

  function automatic logic m_hit();
    return bus.addr_in[31:4] == 28'h0000200;
  endfunction

  function automatic logic m_valid();
    return m_hit() && (bus.addr_in[1:0] == 2'b00) && (bus.width_in != 2'd3);
  endfunction

  function automatic logic m_tx();
    int idx;
    if (frame_rem == 0) return 1'b1;
    idx = (10 * fdiv - frame_rem) / fdiv;
    return frame_bits[idx];
  endfunction

  function automatic logic [31:0] m_rdata();
    logic [31:0] r;
    r = 32'd0;
    if (bus.re_in && m_valid()) begin
      case (bus.addr_in[3:2])
        2'd1: r = {24'd0, 4'(mq.size()), movf, (frame_rem > 0),
                   (mq.size() == 0), (mq.size() == FIFO_DEPTH)};
        2'd2: r = {16'd0, mdiv};
        default: r = 32'd0;
      endcase
    end
    return r;
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      mq.delete();
      frame_rem  = 0;
      fdiv       = 4;
      frame_bits = 10'h3FF;
      mdiv       = 16'd4;
      movf       = 1'b0;
    end else begin
      pre_n   = mq.size();
      div_pre = mdiv;
      if (frame_rem > 0) frame_rem--;
      if (frame_rem == 0 && pre_n > 0) begin
        popped     = mq.pop_front();
        frame_bits = {1'b1, popped, 1'b0};
        fdiv       = int'(div_pre);
        frame_rem  = 10 * int'(div_pre);
      end
      if (bus.we_in && m_valid()) begin
        case (bus.addr_in[3:2])
          2'd0: if (pre_n < FIFO_DEPTH) mq.push_back(bus.wdata_in[7:0]);
                else movf = 1'b1;
          2'd1: movf = 1'b0;
          2'd2: begin
            nd   = (bus.width_in == 2'd0) ? {mdiv[15:8], bus.wdata_in[7:0]}
                                          : bus.wdata_in[15:0];
            mdiv = (nd == 16'd0) ? 16'd1 : nd;
          end
          default: ;
        endcase
      end
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    if (rst) begin
      chk("tx_model",    {31'd0, tx},          {31'd0, m_tx()});
      chk("irq_model",   {31'd0, irq},         {31'd0, (mq.size() == 0) && (frame_rem == 0)});
      chk("sel_model",   {31'd0, bus.sel_out}, {31'd0, m_hit() && (bus.re_in || bus.we_in)});
      chk("rdata_model", bus.rdata_out,        m_rdata());
    end
  end

  // Length of the most recent irq-low stretch, in cycles.
  int low_run = 0;
  int last_low_run = 0;
  always @(negedge clk) begin
    if (rst) begin
      if (!irq) low_run++;
      else begin
        if (low_run > 0) last_low_run = low_run;
        low_run = 0;
      end
    end
  end

  // ---------------- bus tasks (called at posedge+1) ----------------
  task automatic bus_write(input logic [31:0] addr, input logic [1:0] width, input logic [31:0] data);
    bus.we_in    = 1'b1;
    bus.re_in    = 1'b0;
    bus.addr_in  = addr;
    bus.width_in = width;
    bus.wdata_in = data;
    @(posedge clk); #1;
    bus.we_in    = 1'b0;
  endtask

  task automatic bus_read(input string name, input logic [31:0] addr, input logic [31:0] exp);
    bus.re_in    = 1'b1;
    bus.we_in    = 1'b0;
    bus.addr_in  = addr;
    bus.width_in = 2'd2;
    @(negedge clk); #1;
    chk(name, bus.rdata_out, exp);
    @(posedge clk); #1;
    bus.re_in = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int limit);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      if (irq) begin
        seen = 1'b1;
        break;
      end
    end
    n_vec++;
    if (!seen) begin
      n_err++;
      $display("FAIL %s: irq still low after %0d cycles, required high", name, limit);
    end
    @(posedge clk); #1;
  endtask

  logic       samp [0:41];
  logic [9:0] pat55;

  initial begin
    bus.re_in = 1'b0; bus.we_in = 1'b0; bus.width_in = 2'd0;
    bus.addr_in = 32'd0; bus.wdata_in = 32'd0;
    repeat (3) @(posedge clk);
    @(negedge clk); #2 rst = 1'b1;
    @(posedge clk); #1;

    // reset state
    chk("reset_tx",  {31'd0, tx},  32'd1);
    chk("reset_irq", {31'd0, irq}, 32'd1);
    bus_read("reset_status", 32'h2004, 32'h0000_0002);
    bus_read("reset_div",    32'h2008, 32'h0000_0004);
    bus_read("reset_txdata", 32'h2000, 32'h0000_0000);

    // single frame 0x55 at div 4
    bus_write(32'h2000, 2'd2, 32'h0000_0055);
    for (int i = 0; i < 41; i++) begin
      @(negedge clk);
      samp[i] = tx;
    end
    @(negedge clk);
    chk("frame55_irq_after", {31'd0, irq}, 32'd1);
    pat55 = 10'b1_01010101_0;
    for (int k = 0; k < 10; k++)
      chk($sformatf("frame55_bit%0d", k), {31'd0, samp[4*k+2]}, {31'd0, pat55[k]});
    chk("frame55_edge_before", {31'd0, samp[0]}, 32'd1);
    @(posedge clk); #1;

    // burst of seven bytes: five accepted, two dropped
    for (int i = 0; i < 7; i++) bus_write(32'h2000, 2'd0, 32'h11 + i);
    bus_read("burst_status_ovf", 32'h2004, 32'h0000_004D);
    bus_write(32'h2004, 2'd2, 32'h0);
    bus_read("burst_status_clr", 32'h2004, 32'h0000_0045);
    wait_idle("burst_drain", 400);
    chk("burst_contiguous_len", last_low_run, 201);

    // divisor 0 -> 1; mid-frame DIV change does not stretch current frame
    bus_write(32'h2008, 2'd1, 32'h0000_0000);
    bus_read("div_zero_as_one", 32'h2008, 32'h0000_0001);
    bus_write(32'h2000, 2'd2, 32'h0000_00A5);
    @(posedge clk); #1;
    @(posedge clk); #1;
    bus_write(32'h2008, 2'd0, 32'h0000_0008);
    wait_idle("div1_frame", 50);
    chk("div1_frame_len", last_low_run, 11);
    bus_read("div_byte8", 32'h2008, 32'h0000_0008);
    bus_write(32'h2000, 2'd0, 32'h0000_003C);
    wait_idle("div8_frame", 200);
    chk("div8_frame_len", last_low_run, 81);

    // invalid and out-of-window accesses
    bus_write(32'h2001, 2'd0, 32'h0000_00FF);
    bus_write(32'h2000, 2'd3, 32'h0000_00FF);
    bus_read("invalid_status", 32'h2004, 32'h0000_0002);
    bus_read("reserved_read", 32'h200C, 32'h0000_0000);
    bus.re_in = 1'b1; bus.addr_in = 32'h2010; bus.width_in = 2'd2;
    @(negedge clk); #1;
    chk("outside_sel",   {31'd0, bus.sel_out}, 32'd0);
    chk("outside_rdata", bus.rdata_out,        32'd0);
    @(posedge clk); #1;
    bus.re_in = 1'b0;

    // reset mid-DATA with two bytes queued
    bus_write(32'h2008, 2'd2, 32'h0000_0004);
    bus_write(32'h2000, 2'd0, 32'h0000_00AA);
    bus_write(32'h2000, 2'd0, 32'h0000_00BB);
    bus_write(32'h2000, 2'd0, 32'h0000_00CC);
    repeat (6) @(posedge clk);
    @(negedge clk); #2;
    chk("midframe_tx_low", {31'd0, tx}, 32'd0);
    rst = 1'b0;
    #1;
    chk("midframe_rst_tx",  {31'd0, tx},  32'd1);
    chk("midframe_rst_irq", {31'd0, irq}, 32'd1);
    @(negedge clk); #2 rst = 1'b1;
    @(posedge clk); #1;
    bus_read("post_rst_status", 32'h2004, 32'h0000_0002);
    bus_read("post_rst_div",    32'h2008, 32'h0000_0004);
    repeat (60) @(posedge clk);
    #1;
    chk("post_rst_tx_quiet", {31'd0, tx},  32'd1);
    chk("post_rst_irq",      {31'd0, irq}, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/mmio_uart_tx.md
Name: mmio_uart_tx

Overview:
- Memory-mapped UART transmitter that acts as a responder on the processor's data-bus port (ram_re_out / ram_we_out / ram_width_out / ram_addr_out / ram_data).
- Gives test programs a console output path alongside DataRAM, occupying a 16-byte window at BASE_ADDR.
- Store bytes are buffered in a small FIFO and serialized 8N1 on a single TX line.

Parameters:
- BASE_ADDR, 32'h0000_2000, window base; bits [3:0] must be 0.
- FIFO_DEPTH, 4, TX FIFO entries; power of two, ≥2.
- DIV_RESET, 16'd4, reset value of the baud divisor (clock cycles per bit).

Ports:
- clk  in  1  system clock, all state on rising edge.
- rst  in  1  asynchronous, active-low reset.
- re_in  in  1  bus read enable.
- we_in  in  1  bus write enable.
- width_in  in  2  access width: 0=byte, 1=half, 2=word, 3=reserved.
- addr_in  in  32  byte address.
- wdata_in  in  32  write data, little-endian, LSB-aligned.
- rdata_out  out  32  read data, combinational.
- sel_out  out  1  high when addr_in falls inside the window and re_in or we_in is high.
- tx_out  out  1  serial line, idle high.
- irq_out  out  1  high while the FIFO is empty and the serializer is idle.

Behaviour:
- Reset (rst=0, async): FIFO empty, serializer IDLE, tx_out=1, divisor=DIV_RESET, overflow=0, irq_out=1, rdata_out=0.
- Decode: hit = addr_in[31:4]==BASE_ADDR[31:4]. An access is valid only if addr_in[1:0]==0 and width_in!=3.
- Invalid or non-hit accesses: no state change; rdata_out=0.
- Register map (offset = addr_in[3:2]):
  - 0 TXDATA, write: push wdata_in[7:0]; any valid width. Reads return 0.
  - 1 STATUS, read: [0] full, [1] empty, [2] busy (serializer not IDLE), [3] overflow (sticky), [7:4] count, [31:8] 0. Any write clears overflow.
  - 2 DIV, read: {16'b0, div}. Write: byte updates div[7:0]; half/word update div[15:0]. A written value of 0 is stored as 1.
  - 3 reserved: reads 0, writes ignored.
- Reads are combinational in the same cycle as re_in; rdata_out=0 when re_in=0 or no hit.
- If re_in and we_in are both high, the write takes effect at the edge and the read returns pre-edge state.
- Push:
  - At the rising edge, when we_in and a valid TXDATA hit are present and the pre-edge count<FIFO_DEPTH, the byte is pushed.
  - If pre-edge count==FIFO_DEPTH, the byte is dropped and overflow is set, even if a pop occurs in the same cycle.
- Serializer FSM states: IDLE, START, DATA, STOP. It holds a bit counter (0-7) and a cycle counter (0..div-1).
  - IDLE: if the FIFO is non-empty at the edge, pop into the shift register → START, tx_out=0. Latency: write edge N pushes, edge N+1 pops, tx_out falls after edge N+1.
  - START: hold for div cycles → DATA, bit 0.
  - DATA: drive shift[0], LSB first; each bit lasts div cycles; after bit 7 → STOP.
  - STOP: tx_out=1 for div cycles. At the end, if the FIFO is non-empty, pop and go straight to START (no idle gap); otherwise → IDLE.
  - Frame length is exactly 10*div cycles.
- The divisor value is sampled at frame start (IDLE/STOP→START); DIV writes take effect on the next frame.
- FIFO pointers wrap modulo FIFO_DEPTH; count ranges 0..FIFO_DEPTH. Simultaneous push and pop when not full leaves count unchanged.
- irq_out = empty && IDLE, registered-state derived (no combinational path from bus inputs).
- Reset asserted mid-frame: tx_out returns to 1 immediately, FIFO contents are lost, and the divisor reverts to DIV_RESET.

Test Plan:
- Reset, then read STATUS (addr 0x2004, word) → rdata_out=0x00000002; tx_out=1; irq_out=1; read DIV (0x2008) → 0x00000004.
- Word write 0x00000055 to 0x2000 at edge N → tx_out=0 from edge N+1 for 4 cycles, then bits 1,0,1,0,1,0,1,0 at 4 cycles each, then stop 1. Total 40 cycles; irq_out=1 again after the stop bit.
- Five back-to-back byte writes 0x11..0x15 while idle → first pops at the next edge, so all five are accepted with no overflow. Then write 0x16 and 0x17 with 4 queued → 0x16 is accepted only if count<4, otherwise STATUS[3]=1. Frames are contiguous with no idle cycles between stop and next start.
- Half write 0x0000 to DIV → read back 0x00000001; the next frame lasts 10 cycles. A byte write of 0x08 to DIV during a frame does not change the current frame's bit length.
- Misaligned write to 0x2001 and width_in=3 write to 0x2000 → no push, count stays 0; access at 0x2010 → sel_out=0, rdata_out=0.
- Assert rst=0 mid-DATA with 2 bytes queued → tx_out=1 immediately; after release, STATUS=0x00000002 and no further frames are sent.
